// File: rtl/seq_word_comparator_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_word_comparator_if
//  Description : Operand and verdict handshake bundle for seq_word_comparator.
//                The operand channel (in_valid/in_ready/a/b) and the verdict
//                channel (out_valid/out_ready/x_gt_y/x_eq_y/x_lt_y) share
//                one interface.
//  Modports    : master - operand source / verdict consumer side
//                slave  - the comparator itself
//  Signals     : in_valid, in_ready, a[WIDTH], b[WIDTH],
//                out_valid, out_ready, x_gt_y, x_eq_y, x_lt_y
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_word_comparator_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic             x_gt_y;
   logic             x_eq_y;
   logic             x_lt_y;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, x_gt_y, x_eq_y, x_lt_y
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, x_gt_y, x_eq_y, x_lt_y
   );
endinterface
`default_nettype wire

// File: rtl/seq_word_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : seq_word_comparator (with helper comparator_4bit)
//  Description : Multi-cycle unsigned magnitude comparator. The latched
//                operands are scanned one 4-bit slice per cycle, most
//                significant slice first; the first unequal slice decides
//                the verdict.
//  Parameters  : WIDTH - operand width, multiple of 4, >= 4
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - seq_word_comparator_if.slave (operand/verdict
//                       handshakes and verdict flags)
//                busy - high while a scan is in progress
//  Macro       : SEQ_CMP_EARLY_EXIT_EN - when defined, the scan stops at the
//                first unequal slice instead of always running all slices.
//  Revision    : 1.0 - initial release
// ============================================================================

// 4-bit unsigned magnitude compare of one slice.
module comparator_4bit (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic       gt,
   output logic       eq,
   output logic       lt
);
   assign gt = (x > y);
   assign eq = (x == y);
   assign lt = (x < y);
endmodule

module seq_word_comparator #(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_word_comparator_if.slave  bus,
   output logic                  busy
);
   localparam int c_N     = WIDTH / 4;
   localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      VERD_EQ = 2'd0,
      VERD_GT = 2'd1,
      VERD_LT = 2'd2
   } verdict_t;

   state_t             r_state;
   state_t             w_state_nxt;
   verdict_t           r_verdict;
   verdict_t           w_verdict_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [c_IDX_W-1:0] r_idx;
   logic [3:0]         w_a_slice;
   logic [3:0]         w_b_slice;
   logic               w_slice_gt;
   logic               w_slice_eq;
   logic               w_slice_lt;
   logic               w_accept;

   // Only latched operands feed the slice mux, so bus.a/bus.b may change
   // freely once the scan has started.
   always_comb begin
      w_a_slice = 4'd0;
      w_b_slice = 4'd0;
      for (int i = 0; i < c_N; i++) begin
         if (r_idx == c_IDX_W'(i)) begin
            w_a_slice = r_a[i*4 +: 4];
            w_b_slice = r_b[i*4 +: 4];
         end
      end
   end

   comparator_4bit u_slice_cmp (
      .x  (w_a_slice),
      .y  (w_b_slice),
      .gt (w_slice_gt),
      .eq (w_slice_eq),
      .lt (w_slice_lt)
   );

   assign w_accept = (r_state == ST_IDLE) && bus.in_valid;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and verdict update.
   always_comb begin
      w_state_nxt   = r_state;
      w_verdict_nxt = r_verdict;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_state_nxt = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            // Once a verdict other than EQ is recorded, lower slices are
            // not allowed to overwrite it.
            if (r_verdict == VERD_EQ) begin
               if (w_slice_gt) begin
                  w_verdict_nxt = VERD_GT;
               end else if (w_slice_lt) begin
                  w_verdict_nxt = VERD_LT;
               end
            end
            if (r_idx == '0) begin
               w_state_nxt = ST_DONE;
            end
`ifdef SEQ_CMP_EARLY_EXIT_EN
            else if ((r_verdict == VERD_EQ) && !w_slice_eq) begin
               w_state_nxt = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand, slice index and verdict registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_idx     <= '0;
         r_verdict <= VERD_EQ;
      end else if (w_accept) begin
         r_a       <= bus.a;
         r_b       <= bus.b;
         r_idx     <= c_IDX_LAST;
         r_verdict <= VERD_EQ;
      end else if (r_state == ST_COMPARE) begin
         r_idx     <= r_idx - c_IDX_ONE;
         r_verdict <= w_verdict_nxt;
      end
   end

   // Every output is decoded from registers only; flags are gated by DONE
   // so they read zero whenever out_valid is low.
   assign bus.in_ready  = (r_state == ST_IDLE);
   assign busy          = (r_state == ST_COMPARE);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.x_gt_y    = (r_state == ST_DONE) && (r_verdict == VERD_GT);
   assign bus.x_eq_y    = (r_state == ST_DONE) && (r_verdict == VERD_EQ);
   assign bus.x_lt_y    = (r_state == ST_DONE) && (r_verdict == VERD_LT);

endmodule
`default_nettype wire

// File: tb/tb_seq_word_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_word_comparator
//  Description : Directed self-checking bench for seq_word_comparator,
//                WIDTH=16. Expected latencies follow SEQ_CMP_EARLY_EXIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_word_comparator;
   localparam int c_WIDTH = 16;
`ifdef SEQ_CMP_EARLY_EXIT_EN
   localparam int c_LAT_TOP_DIFF = 1;
`else
   localparam int c_LAT_TOP_DIFF = 4;
`endif
   localparam int c_LAT_FULL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   seq_word_comparator_if #(.WIDTH(c_WIDTH)) bus ();

   seq_word_comparator #(.WIDTH(c_WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   // Present one operand pair, return #1 after the accept edge.
   task automatic send(input logic [15:0] xa, input logic [15:0] xb);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = xa;
      bus.b        = xb;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Edges counted from the accept edge until out_valid is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b1;
      bus.a         = 16'h0001;
      bus.b         = 16'h0002;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus.in_ready, bus.out_valid, busy, bus.x_gt_y, bus.x_eq_y, bus.x_lt_y} !== 6'b100000) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=100000",
                  {bus.in_ready, bus.out_valid, busy, bus.x_gt_y, bus.x_eq_y, bus.x_lt_y});
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({bus.in_ready, busy} !== 2'b10) begin
         bad++;
         $display("FAIL reset_release_idle got=%b exp=10", {bus.in_ready, busy});
      end
   endtask

   task automatic test_equal();
      int lat;
      bus.out_ready = 1'b1;
      send(16'h1234, 16'h1234);
      total++;
      if ({bus.in_ready, busy} !== 2'b01) begin
         bad++;
         $display("FAIL equal_busy got=%b exp=01", {bus.in_ready, busy});
      end
      wait_done(lat);
      total++;
      if (lat !== c_LAT_FULL) begin
         bad++;
         $display("FAIL equal_latency got=%0d exp=%0d", lat, c_LAT_FULL);
      end
      total++;
      if ({bus.x_gt_y, bus.x_eq_y, bus.x_lt_y, busy} !== 4'b0100) begin
         bad++;
         $display("FAIL equal_flags got=%b exp=0100", {bus.x_gt_y, bus.x_eq_y, bus.x_lt_y, busy});
      end
      @(posedge clk);
      #1;
      total++;
      if ({bus.in_ready, bus.out_valid, bus.x_gt_y, bus.x_eq_y, bus.x_lt_y} !== 5'b10000) begin
         bad++;
         $display("FAIL equal_after_handshake got=%b exp=10000",
                  {bus.in_ready, bus.out_valid, bus.x_gt_y, bus.x_eq_y, bus.x_lt_y});
      end
   endtask

   task automatic test_gt_top_slice();
      int lat;
      bus.out_ready = 1'b1;
      send(16'h9000, 16'h6FFF);
      wait_done(lat);
      total++;
      if (lat !== c_LAT_TOP_DIFF) begin
         bad++;
         $display("FAIL gt_top_latency got=%0d exp=%0d", lat, c_LAT_TOP_DIFF);
      end
      total++;
      if ({bus.x_gt_y, bus.x_eq_y, bus.x_lt_y} !== 3'b100) begin
         bad++;
         $display("FAIL gt_top_flags got=%b exp=100", {bus.x_gt_y, bus.x_eq_y, bus.x_lt_y});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_lt_last_slice();
      int lat;
      bus.out_ready = 1'b1;
      send(16'h0003, 16'h000A);
      wait_done(lat);
      total++;
      if (lat !== c_LAT_FULL) begin
         bad++;
         $display("FAIL lt_last_latency got=%0d exp=%0d", lat, c_LAT_FULL);
      end
      total++;
      if ({bus.x_gt_y, bus.x_eq_y, bus.x_lt_y} !== 3'b001) begin
         bad++;
         $display("FAIL lt_last_flags got=%b exp=001", {bus.x_gt_y, bus.x_eq_y, bus.x_lt_y});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      int lat;
      bus.out_ready = 1'b0;
      send(16'hFFFF, 16'hFFFE);
      wait_done(lat);
      total++;
      if (lat !== c_LAT_FULL) begin
         bad++;
         $display("FAIL backpressure_latency got=%0d exp=%0d", lat, c_LAT_FULL);
      end
      bus.in_valid = 1'b1;
      bus.a        = 16'h0000;
      bus.b        = 16'h0001;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         total++;
         if ({bus.out_valid, bus.in_ready, bus.x_gt_y, bus.x_eq_y, bus.x_lt_y} !== 5'b10100) begin
            bad++;
            $display("FAIL backpressure_hold cycle=%0d got=%b exp=10100", i,
                     {bus.out_valid, bus.in_ready, bus.x_gt_y, bus.x_eq_y, bus.x_lt_y});
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
         bad++;
         $display("FAIL backpressure_release got=%b exp=100", {bus.in_ready, bus.out_valid, busy});
      end
   endtask

   task automatic test_reset_mid_compare();
      int   lat;
      logic seen;
      bus.out_ready = 1'b1;
      send(16'h1200, 16'h1300);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.in_ready, bus.out_valid, busy, bus.x_gt_y, bus.x_eq_y, bus.x_lt_y} !== 6'b100000) begin
         bad++;
         $display("FAIL reset_mid_immediate got=%b exp=100000",
                  {bus.in_ready, bus.out_valid, busy, bus.x_gt_y, bus.x_eq_y, bus.x_lt_y});
      end
      @(posedge clk);
      #1;
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_no_result got=%b exp=0", seen);
      end
      send(16'h0005, 16'h0005);
      wait_done(lat);
      total++;
      if (lat !== c_LAT_FULL) begin
         bad++;
         $display("FAIL reset_mid_next_latency got=%0d exp=%0d", lat, c_LAT_FULL);
      end
      total++;
      if ({bus.x_gt_y, bus.x_eq_y, bus.x_lt_y} !== 3'b010) begin
         bad++;
         $display("FAIL reset_mid_next_flags got=%b exp=010", {bus.x_gt_y, bus.x_eq_y, bus.x_lt_y});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_operand_change();
      int lat;
      bus.out_ready = 1'b1;
      send(16'h4000, 16'h3FFF);
      lat = 0;
      // Live operands now say a < b; only the latched pair may matter.
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         bus.a = 16'h0000 + 16'(lat);
         bus.b = 16'hFFFF - 16'(lat);
         @(posedge clk);
         #1;
         lat++;
      end
      total++;
      if (lat !== c_LAT_TOP_DIFF) begin
         bad++;
         $display("FAIL operand_change_latency got=%0d exp=%0d", lat, c_LAT_TOP_DIFF);
      end
      total++;
      if ({bus.x_gt_y, bus.x_eq_y, bus.x_lt_y} !== 3'b100) begin
         bad++;
         $display("FAIL operand_change_flags got=%b exp=100", {bus.x_gt_y, bus.x_eq_y, bus.x_lt_y});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int   cyc;
      int   t0;
      int   t1;
      logic prev;
      logic [2:0] flags0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'h0001;
      bus.b        = 16'h0002;
      cyc    = 0;
      t0     = -1;
      t1     = -1;
      prev   = 1'b0;
      flags0 = 3'b000;
      while (t1 < 0 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.out_valid === 1'b1 && !prev) begin
            if (t0 < 0) begin
               t0     = cyc;
               flags0 = {bus.x_gt_y, bus.x_eq_y, bus.x_lt_y};
            end else begin
               t1 = cyc;
            end
         end
         prev = bus.out_valid;
      end
      bus.in_valid = 1'b0;
      total++;
      if (t0 !== 5) begin
         bad++;
         $display("FAIL b2b_first_result got=%0d exp=5", t0);
      end
      total++;
      if (t1 - t0 !== 6) begin
         bad++;
         $display("FAIL b2b_period got=%0d exp=6", t1 - t0);
      end
      total++;
      if (flags0 !== 3'b001) begin
         bad++;
         $display("FAIL b2b_flags got=%b exp=001", flags0);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_equal();
      test_gt_top_slice();
      test_lt_last_slice();
      test_backpressure();
      test_reset_mid_compare();
      test_operand_change();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
